// File: rtl/wait_sched_pkg.sv
// Shared types and helpers for the wait-slot scheduler: FSM state encoding,
// default sizing, and the raw-count to load-value conversion.
package wait_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  // A zero wait still occupies one COUNT cycle, so it is loaded as 1.
  function automatic logic [31:0] load_count(input logic [31:0] raw);
    return (raw == 32'd0) ? 32'd1 : raw;
  endfunction

endpackage

// File: rtl/wait_slot_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i,
// wrapping around to index 0.
module rr_arbiter
  import wait_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic               grant_valid_o,
  output logic [PTR_W-1:0]   grant_idx_o
);

  logic [PTR_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(rr_ptr_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/wait_slot_scheduler.sv
// Shared wait timer: grants one requesting thread at a time round-robin,
// counts its wait down and pulses that thread's done for one cycle.
module wait_slot_scheduler
  import wait_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_cycles,
  input  logic                     cancel,
  output logic [NUM_REQ-1:0]       done,
  output logic [PTR_W-1:0]         grant_id,
  output logic                     busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic               arb_valid;
  logic [PTR_W-1:0]   arb_idx;
  logic [CNT_W-1:0]   cyc [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign cyc[g] = req_cycles[g*CNT_W +: CNT_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i         (req),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (arb_valid),
    .grant_idx_o   (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    done_d     = '0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = COUNT;
          grant_id_d = arb_idx;
          cnt_d      = CNT_W'(load_count(32'(cyc[arb_idx])));
          rr_ptr_d   = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          busy_d     = 1'b1;
        end
      end
      COUNT: begin
        // Abort wins over a completion landing in the same cycle.
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = NUM_REQ'(1) << grant_id_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign done     = done_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wait_slot_scheduler.sv
// Directed testbench for wait_slot_scheduler with NUM_REQ=4, CNT_W=8.
module tb_wait_slot_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_cycles;
  logic        cancel;
  logic [3:0]  done;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wait_slot_scheduler #(.NUM_REQ(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_cycles (req_cycles),
    .cancel     (cancel),
    .done       (done),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] cyc;
    logic        cancel;
    logic [3:0]  e_done;
    logic        e_busy;
    logic [1:0]  e_grant;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] c, input logic cn,
                              input logic [3:0] ed, input logic eb, input logic [1:0] eg);
    vec_t v;
    v.req = r; v.cyc = c; v.cancel = cn; v.e_done = ed; v.e_busy = eb; v.e_grant = eg;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_cycles = '0; cancel = 1'b0;
    reset = 1'b1;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int first;
    reset = 1'b1; req = '0; req_cycles = '0; cancel = 1'b0;
    #2;
    check("reset done", done, 4'b0000);
    check("reset busy", busy, 1'b0);
    check("reset grant", grant_id, 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request (count 3, changed mid-wait), zero count, cancel, idle cancel.
    tbl.push_back(mk(4'b0001, 32'h0000_0003, 1'b0, 4'b0000, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0001, 32'h0000_0007, 1'b0, 4'b0000, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0001, 32'h0000_0007, 1'b0, 4'b0000, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0001, 32'h0000_0007, 1'b0, 4'b0001, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 2'd0));
    tbl.push_back(mk(4'b0100, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 2'd2));
    tbl.push_back(mk(4'b0100, 32'h0000_0000, 1'b0, 4'b0100, 1'b0, 2'd2));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 2'd2));
    tbl.push_back(mk(4'b0010, 32'h0000_0A00, 1'b0, 4'b0000, 1'b1, 2'd1));
    tbl.push_back(mk(4'b0010, 32'h0000_0A00, 1'b0, 4'b0000, 1'b1, 2'd1));
    tbl.push_back(mk(4'b0010, 32'h0000_0A00, 1'b0, 4'b0000, 1'b1, 2'd1));
    tbl.push_back(mk(4'b0010, 32'h0000_0A00, 1'b0, 4'b0000, 1'b1, 2'd1));
    tbl.push_back(mk(4'b0110, 32'h0001_0A00, 1'b1, 4'b0000, 1'b0, 2'd1));
    tbl.push_back(mk(4'b0110, 32'h0001_0A00, 1'b0, 4'b0000, 1'b1, 2'd2));
    tbl.push_back(mk(4'b0110, 32'h0001_0A00, 1'b0, 4'b0100, 1'b0, 2'd2));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 2'd2));
    tbl.push_back(mk(4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd2));

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; req_cycles = tbl[i].cyc; cancel = tbl[i].cancel;
      step();
      check($sformatf("vec%0d done", i), done, tbl[i].e_done);
      check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d grant", i), grant_id, tbl[i].e_grant);
    end

    // Round-robin: all requesters held high, count 2 each.
    do_reset();
    req = 4'b1111; req_cycles = 32'h0202_0202;
    for (int c = 1; c <= 20; c++) begin
      logic [3:0] exp_d;
      step();
      exp_d = (c % 4 == 3) ? (4'b0001 << (((c - 3) / 4) % 4)) : 4'b0000;
      check($sformatf("rr cycle%0d done", c), done, exp_d);
    end

    // Asynchronous reset in the middle of a long wait.
    do_reset();
    req = 4'b1000; req_cycles = 32'hC800_0000;
    for (int c = 0; c < 5; c++) step();
    check("midrst busy before", busy, 1'b1);
    check("midrst grant before", grant_id, 2'd3);
    #2;
    reset = 1'b1;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 4'b0000);
    check("midrst grant", grant_id, 2'd0);
    req = 4'b1001; req_cycles = 32'hC800_0001;
    #1;
    reset = 1'b0;
    step();
    check("postrst grant", grant_id, 2'd0);
    check("postrst busy", busy, 1'b1);

    // Full-scale count of 255.
    do_reset();
    req = 4'b0001; req_cycles = 32'h0000_00FF;
    first = 0;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 255) check("maxcnt busy@255", busy, 1'b1);
      if (done == 4'b0001 && first == 0) first = c;
      if (first != 0) break;
    end
    check("maxcnt done cycle", first, 256);
    check("maxcnt busy in done", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
